tempo_tick_gen: RTL and testbench
=================================

# tempo_tick_gen

Parametrised tempo tick generator: the successor to the fixed 8-speed clock divider in the control path. It emits a beat pulse, a sub-beat pulse at SUBDIV per beat, and a bar position. It supports run/stop, resync to the bar start, and tempo changes that take effect only on beat boundaries. It feeds the control FSM and the note-sequencing datapath; all outputs are registered and synchronous to `clk`.

## Interface
- CLK_HZ, 50_000_000, frequency of `clk` in Hz.
- SUBDIV, 4, sub-ticks per beat (>= 1).
- BEATS_PER_BAR, 4, beats per bar (>= 1).
- BEAT_W, 2, width of `beat_idx`; must satisfy 2^BEAT_W >= BEATS_PER_BAR.
- CNT_W, 27, countdown counter width; must hold the largest sub-tick length minus 1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = generate ticks, 0 = stopped.
- resync  in  1  single-cycle pulse; restart the bar at beat 0.
- speed  in  3  tempo select: 0..7 = 40, 60, 80, 100, 120, 140, 180, 220 beats/min.
- sub_tick  out  1  one-cycle pulse at every sub-beat, including the beat itself.
- beat_tick  out  1  one-cycle pulse at every beat; coincides with a sub_tick.
- bar_start  out  1  one-cycle pulse at beat 0 of each bar; coincides with beat_tick.
- beat_idx  out  BEAT_W  beat index within the bar; valid from beat_tick onward.
- running  out  1  1 while in RUN.

## Operation
- Beat period P(s) = floor(CLK_HZ*60/bpm(s)) clocks, computed at elaboration for all 8 entries.
- Sub-tick length L = floor(P/SUBDIV) for sub-beats 0..SUBDIV-2.
- The last sub-beat has length P - (SUBDIV-1)*L, which absorbs the remainder so every beat is exactly P clocks.
- Elaboration fails if P < SUBDIV for any entry.
- States:
  - IDLE: counters cleared, no pulses, running=0.
  - RUN: count down, generate pulses.
- IDLE -> RUN when `run`=1 is sampled. The next cycle is the first RUN cycle, and on that cycle sub_tick, beat_tick and bar_start are all 1 and beat_idx=0.
- RUN -> IDLE when `run`=0 is sampled. From the next cycle: no pulses, running=0, beat_idx=0, sub index=0. Any partial beat is discarded; there is no resume.
- In RUN, a down-counter is loaded with (length-1) on each tick cycle and decrements each clock. When it reads 0, the next cycle is a tick cycle.
- On each tick cycle the sub index advances (wrapping at SUBDIV), and the sub index equals 0 exactly when beat_tick=1.
- beat_idx increments on each beat_tick, wrapping BEATS_PER_BAR-1 -> 0. bar_start=1 iff beat_tick=1 and the new beat_idx=0.
- Tempo: `speed` is latched only on the cycle before a beat tick, i.e. when the counter expires on the last sub-beat, or on IDLE->RUN. The new P/L apply from that beat. Changes mid-beat are not seen until the next beat.
- resync in RUN:
  - The next cycle is forced to be a tick cycle with sub index 0 and beat_idx=0, so sub_tick=beat_tick=bar_start=1.
  - `speed` is relatched.
  - The counter is reloaded.
- resync in IDLE, or together with `run`=0, is ignored. resync together with a natural expiry yields a single tick cycle, which is the resync tick.

## Timing
- Reset values: sub_tick=0, beat_tick=0, bar_start=0, beat_idx=0, running=0, state IDLE, counter=0. Reset dominates run and resync.
- Latency: run sampled 1 at edge N -> pulses at cycle N+1. resync sampled at edge N -> pulses at cycle N+1.
- In steady state, sub_tick spacing is exactly L clocks, except the gap into the next beat, which is P-(SUBDIV-1)*L. beat_tick spacing is exactly P clocks.
- The pulses are one cycle wide; sub_tick is never high on two consecutive cycles unless L=1.
- Reset asserted mid-beat: IDLE with all-zero outputs on the next cycle. After reset deasserts with run=1, the first pulses arrive one cycle later.

## Test plan
- CLK_HZ=240, SUBDIV=4, speed=0 (P=360, L=90): assert run -> sub_tick every 90 cycles, beat_tick every 360, bar_start every 1440, beat_idx 0,1,2,3,0.
- CLK_HZ=240, speed=5 (P=102, L=25): sub_tick gaps 25, 25, 25, 27 repeating; beat_tick gap exactly 102.
- speed changed 0->4 at 30 cycles after a beat -> the current beat still lasts 360; from the next beat the period is 120 (L=30).
- resync 200 cycles into beat 2 -> next cycle has sub_tick=beat_tick=bar_start=1 and beat_idx=0, then the next sub_tick follows 90 cycles later. resync while run=0 -> no pulses.
- Drop run mid-beat -> running=0 and no pulses next cycle. Reassert run -> immediate bar_start with beat_idx=0.
- Reset mid-run together with run=1 and resync=1 -> all outputs 0 on the cycle after reset. On release with run=1, the first bar_start arrives one cycle later.

Source files
------------

// File: rtl/tempo_tick_gen_if.sv
// Control/status bundle between the tempo tick generator and its consumers.
// The master drives run/resync/speed; the slave (the generator) drives the tick outputs.
interface tempo_tick_gen_if #(
  parameter int BEAT_W = 2
);
  logic              run;
  logic              resync;
  logic [2:0]        speed;
  logic              sub_tick;
  logic              beat_tick;
  logic              bar_start;
  logic [BEAT_W-1:0] beat_idx;
  logic              running;

  modport master (
    output run, resync, speed,
    input  sub_tick, beat_tick, bar_start, beat_idx, running
  );

  modport slave (
    input  run, resync, speed,
    output sub_tick, beat_tick, bar_start, beat_idx, running
  );
endinterface

// File: rtl/tempo_tick_gen.sv
// Tempo tick generator: beat, sub-beat and bar-position pulses derived from a
// per-tempo countdown, with run/stop, bar resync and beat-aligned tempo changes.
module tempo_tick_gen #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SUBDIV        = 4,
  parameter int BEATS_PER_BAR = 4,
  parameter int BEAT_W        = 2,
  parameter int CNT_W         = 27
) (
  input  logic            clk,
  input  logic            reset,
  tempo_tick_gen_if.slave tt
);

  localparam int SUB_W = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;

  function automatic longint beat_period(input int s);
    longint bpm;
    case (s)
      0:       bpm = 40;
      1:       bpm = 60;
      2:       bpm = 80;
      3:       bpm = 100;
      4:       bpm = 120;
      5:       bpm = 140;
      6:       bpm = 180;
      default: bpm = 220;
    endcase
    return (longint'(CLK_HZ) * 64'sd60) / bpm;
  endfunction

  // Counter reload values (length-1); the last sub-beat absorbs the division remainder.
  function automatic logic [CNT_W-1:0] reload_val(input int s, input bit last);
    longint p;
    longint l;
    p = beat_period(s);
    l = p / longint'(SUBDIV);
    if (last) return CNT_W'(p - longint'(SUBDIV - 1) * l - 64'sd1);
    return CNT_W'(l - 64'sd1);
  endfunction

  localparam logic [CNT_W-1:0] RLD_MID [8] = '{
    reload_val(0, 1'b0), reload_val(1, 1'b0), reload_val(2, 1'b0), reload_val(3, 1'b0),
    reload_val(4, 1'b0), reload_val(5, 1'b0), reload_val(6, 1'b0), reload_val(7, 1'b0)
  };
  localparam logic [CNT_W-1:0] RLD_LAST [8] = '{
    reload_val(0, 1'b1), reload_val(1, 1'b1), reload_val(2, 1'b1), reload_val(3, 1'b1),
    reload_val(4, 1'b1), reload_val(5, 1'b1), reload_val(6, 1'b1), reload_val(7, 1'b1)
  };

  for (genvar g = 0; g < 8; g++) begin : g_chk
    if (beat_period(g) < longint'(SUBDIV)) begin : g_short
      $error("tempo_tick_gen: beat period shorter than SUBDIV");
    end
    if (beat_period(g) - longint'(SUBDIV - 1) * (beat_period(g) / longint'(SUBDIV))
        > (64'sd1 <<< CNT_W)) begin : g_wide
      $error("tempo_tick_gen: CNT_W too narrow for the longest sub-beat");
    end
  end
  if ((1 << BEAT_W) < BEATS_PER_BAR) begin : g_beat_w
    $error("tempo_tick_gen: BEAT_W too narrow for BEATS_PER_BAR");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SUB_W-1:0]  sub_idx;
  logic [2:0]        spd;

  logic              tick_go;
  logic              restart;
  logic [SUB_W-1:0]  sub_nxt;
  logic              beat_nxt;
  logic [2:0]        spd_nxt;
  logic [BEAT_W-1:0] idx_nxt;
  logic [CNT_W-1:0]  rld_nxt;

  // Next tick-cycle values; a start from IDLE and a resync both restart the bar.
  always_comb begin
    restart  = (state == IDLE) || tt.resync;
    tick_go  = tt.run && ((state == IDLE) || tt.resync || (cnt == '0));
    sub_nxt  = (restart || sub_idx == SUB_W'(SUBDIV - 1)) ? '0 : sub_idx + SUB_W'(1);
    beat_nxt = (sub_nxt == '0);
    spd_nxt  = beat_nxt ? tt.speed : spd;
    idx_nxt  = tt.beat_idx;
    if (restart)
      idx_nxt = '0;
    else if (beat_nxt)
      idx_nxt = (tt.beat_idx == BEAT_W'(BEATS_PER_BAR - 1)) ? '0 : tt.beat_idx + BEAT_W'(1);
    rld_nxt = (sub_nxt == SUB_W'(SUBDIV - 1)) ? RLD_LAST[spd_nxt] : RLD_MID[spd_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sub_idx      <= '0;
      spd          <= '0;
      tt.sub_tick  <= 1'b0;
      tt.beat_tick <= 1'b0;
      tt.bar_start <= 1'b0;
      tt.beat_idx  <= '0;
      tt.running   <= 1'b0;
    end else begin
      tt.sub_tick  <= 1'b0;
      tt.beat_tick <= 1'b0;
      tt.bar_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tt.run) begin
            state      <= RUN;
            tt.running <= 1'b1;
          end
        end
        RUN: begin
          if (!tt.run) begin
            state       <= IDLE;
            tt.running  <= 1'b0;
            cnt         <= '0;
            sub_idx     <= '0;
            tt.beat_idx <= '0;
          end else if (!tick_go) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
      if (tick_go) begin
        cnt          <= rld_nxt;
        sub_idx      <= sub_nxt;
        spd          <= spd_nxt;
        tt.sub_tick  <= 1'b1;
        tt.beat_tick <= beat_nxt;
        tt.bar_start <= beat_nxt && (idx_nxt == '0);
        tt.beat_idx  <= idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tempo_tick_gen.sv
// Randomized scoreboard bench for tempo_tick_gen: a time-into-beat reference model
// queues the expected outputs each cycle and a negedge monitor compares them.
module tb_tempo_tick_gen;
  localparam int CLK_HZ = 240;
  localparam int SUBDIV = 4;
  localparam int BPB    = 4;
  localparam int BEAT_W = 2;
  localparam int CNT_W  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tempo_tick_gen_if #(.BEAT_W(BEAT_W)) io ();

  tempo_tick_gen #(
    .CLK_HZ(CLK_HZ), .SUBDIV(SUBDIV), .BEATS_PER_BAR(BPB), .BEAT_W(BEAT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tt(io)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              sub;
    logic              beat;
    logic              bar;
    logic [BEAT_W-1:0] idx;
    logic              run;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  int BPM [8] = '{40, 60, 80, 100, 120, 140, 180, 220};

  // Reference model: position inside the current beat and that beat's period.
  bit m_on   = 1'b0;
  int m_t    = 0;
  int m_per  = 360;
  int m_bidx = 0;

  function automatic int per_of(input logic [2:0] s);
    return (CLK_HZ * 60) / BPM[s];
  endfunction

  task automatic model_step();
    obs_t e;
    int   l;
    e = '0;
    if (reset) begin
      m_on = 1'b0; m_t = 0; m_bidx = 0;
    end else if (!m_on) begin
      if (io.run) begin
        m_on = 1'b1; m_t = 0; m_per = per_of(io.speed); m_bidx = 0; e.beat = 1'b1;
      end
    end else if (!io.run) begin
      m_on = 1'b0; m_t = 0; m_bidx = 0;
    end else if (io.resync) begin
      m_t = 0; m_per = per_of(io.speed); m_bidx = 0; e.beat = 1'b1;
    end else begin
      m_t++;
      if (m_t == m_per) begin
        m_t = 0; m_per = per_of(io.speed); m_bidx = (m_bidx + 1) % BPB; e.beat = 1'b1;
      end
    end
    if (m_on) begin
      l     = m_per / SUBDIV;
      e.sub = (m_t % l == 0) && (m_t / l < SUBDIV);
      e.bar = e.beat && (m_bidx == 0);
      e.idx = BEAT_W'(m_bidx);
      e.run = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Apply inputs for the next edge, then record what that edge should produce.
  task automatic step(input bit rst_i, input bit run_i, input bit rs_i, input logic [2:0] sp_i);
    reset     = rst_i;
    io.run    = run_i;
    io.resync = rs_i;
    io.speed  = sp_i;
    @(posedge clk);
    #1;
    model_step();
  endtask

  obs_t mon_e;
  obs_t mon_a;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {io.sub_tick, io.beat_tick, io.bar_start, io.beat_idx, io.running};
        tests++;
        if (mon_a !== mon_e) begin
          fails++;
          $display("FAIL outputs cyc=%0d got sub=%b beat=%b bar=%b idx=%0d run=%b want sub=%b beat=%b bar=%b idx=%0d run=%b",
                   cyc, mon_a.sub, mon_a.beat, mon_a.bar, mon_a.idx, mon_a.run,
                   mon_e.sub, mon_e.beat, mon_e.bar, mon_e.idx, mon_e.run);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  bit         r_run;
  logic [2:0] r_spd;
  int         seg_len;

  initial begin
    io.run = 1'b0; io.resync = 1'b0; io.speed = 3'd0;
    repeat (3) step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    // Slowest tempo over more than a full bar.
    repeat (1500) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // Uneven last sub-beat at 140 bpm.
    repeat (450) step(0, 1, 0, 5);
    // Tempo change 30 cycles into a beat only applies at the next beat.
    step(0, 0, 0, 0);
    repeat (31) step(0, 1, 0, 0);
    repeat (700) step(0, 1, 0, 4);
    // Resync 200 cycles into beat 2.
    step(0, 0, 0, 0);
    repeat (360 + 200) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (200) step(0, 1, 0, 0);
    // Resync while stopped is ignored.
    step(0, 0, 0, 0);
    step(0, 0, 1, 3);
    repeat (5) step(0, 0, 0, 0);
    // Drop run mid-beat, then restart.
    repeat (150) step(0, 1, 0, 2);
    step(0, 0, 0, 2);
    repeat (100) step(0, 1, 0, 2);
    // Reset mid-run with run and resync held high, then release with run=1.
    repeat (100) step(0, 1, 0, 1);
    step(1, 1, 1, 1);
    repeat (200) step(0, 1, 0, 1);
    // Randomized segments: tempo changes, resyncs, run toggles and occasional resets.
    r_run = 1'b1;
    r_spd = 3'd6;
    for (int seg = 0; seg < 24; seg++) begin
      seg_len = $urandom_range(60, 500);
      r_spd   = 3'($urandom_range(0, 7));
      for (int i = 0; i < seg_len; i++) begin
        if ($urandom_range(0, 99) == 0)  r_spd = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 299) == 0) r_run = ~r_run;
        step(($urandom_range(0, 999) == 0), r_run, ($urandom_range(0, 149) == 0), r_spd);
      end
      r_run = 1'b1;
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
